// File: rtl/disp_pkg.sv
// Shared state encoding, segment codes, digit positions and field widths
// for the seg_display_drv time display.
package disp_pkg;

  typedef enum logic [2:0] {
    S_CAPTURE = 3'd0,
    S_CONV_H  = 3'd1,
    S_CONV_M  = 3'd2,
    S_CONV_S  = 3'd3,
    S_CONV_MS = 3'd4,
    S_COMMIT  = 3'd5
  } disp_state_e;

  localparam int W_HOURS = 4;
  localparam int W_MINS  = 6;
  localparam int W_SECS  = 6;
  localparam int W_MSECS = 10;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] DIG_MS_T = 3'd0;
  localparam logic [2:0] DIG_MS_H = 3'd1;
  localparam logic [2:0] DIG_S_U  = 3'd2;
  localparam logic [2:0] DIG_S_T  = 3'd3;
  localparam logic [2:0] DIG_M_U  = 3'd4;
  localparam logic [2:0] DIG_M_T  = 3'd5;
  localparam logic [2:0] DIG_H_U  = 3'd6;
  localparam logic [2:0] DIG_H_T  = 3'd7;

  function automatic logic [3:0] bcd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_drv_if.sv
// Time bus from the clock/stopwatch top plus the display pin bundle.
interface seg_display_drv_if;
  import disp_pkg::*;

  // No handshake: the time bus is level-signalled and sampled once per
  // conversion pass; the pin outputs are plain registered levels.
  logic                 Control;
  logic [W_HOURS-1:0]   Hours;
  logic [W_MINS-1:0]    Mins;
  logic [W_SECS-1:0]    Secs;
  logic [W_MSECS-1:0]   MSecs;
  logic                 AM_PM;
  logic                 Alarm;
  logic [6:0]           Seg;
  logic                 Dp;
  logic [7:0]           Digit_En;
  disp_state_e          dbg_state;

  modport master (output Control, Hours, Mins, Secs, MSecs, AM_PM, Alarm,
                  input  Seg, Dp, Digit_En, dbg_state);
  modport slave  (input  Control, Hours, Mins, Secs, MSecs, AM_PM, Alarm,
                  output Seg, Dp, Digit_En, dbg_state);
endinterface

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble: one load cycle, then nbits_i shift cycles; done_o
// pulses in the cycle the finished BCD digits are first readable.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [9:0] value_i,
  input  logic [3:0] nbits_i,
  output logic [3:0] bcd2_o,
  output logic [3:0] bcd1_o,
  output logic [3:0] bcd0_o,
  output logic       done_o
);

  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj_w;
  logic [3:0]  cnt_q;
  logic        done_q;

  always_comb begin
    bcd_adj_w = {bcd_adj(bcd_q[11:8]), bcd_adj(bcd_q[7:4]), bcd_adj(bcd_q[3:0])};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // Left-align the field so its MSB is shifted out first
        bin_q <= value_i << (4'd10 - nbits_i);
        bcd_q <= '0;
        cnt_q <= nbits_i;
      end else if (cnt_q != 4'd0) begin
        {bcd_q, bin_q} <= {bcd_adj_w[10:0], bin_q, 1'b0};
        cnt_q          <= cnt_q - 4'd1;
        done_q         <= (cnt_q == 4'd1);
      end
    end
  end

  assign bcd2_o = bcd_q[11:8];
  assign bcd1_o = bcd_q[7:4];
  assign bcd0_o = bcd_q[3:0];
  assign done_o = done_q;

endmodule

// File: rtl/seg_display_drv.sv
// 8-digit multiplexed 7-segment driver: 32-cycle BCD conversion pass, scan
// and alarm blink. Define LEAD_BLANK_EN to blank a leading zero in Hours.
module seg_display_drv
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 5,
  parameter int BLINK_DIV = 1250
) (
  input  logic                Clock_5K,
  input  logic                Reset,
  seg_display_drv_if.slave    bus
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] N_H  = 4'(W_HOURS);
  localparam logic [3:0] N_M  = 4'(W_MINS);
  localparam logic [3:0] N_S  = 4'(W_SECS);
  localparam logic [3:0] N_MS = 4'(W_MSECS);

  disp_state_e         state_q;
  logic [3:0]          step_q;
  logic                start_q;
  logic [9:0]          val_q;
  logic [3:0]          nbits_q;
  logic                cap_ctrl_q, cap_ampm_q;
  logic [W_MINS-1:0]   cap_m_q;
  logic [W_SECS-1:0]   cap_s_q;
  logic [W_MSECS-1:0]  cap_ms_q;
  logic [7:0]          h_bcd_q, m_bcd_q, s_bcd_q;
  logic [7:0]          disp_h_q, disp_m_q, disp_s_q, disp_ms_q;
  logic                disp_ctrl_q, disp_ampm_q;
  logic [3:0]          bcd2, bcd1, bcd0;
  logic                conv_done;

  bin2bcd_seq u_b2b (
    .clk_i   (Clock_5K),
    .rst_ni  (Reset),
    .start_i (start_q),
    .value_i (val_q),
    .nbits_i (nbits_q),
    .bcd2_o  (bcd2),
    .bcd1_o  (bcd1),
    .bcd0_o  (bcd0),
    .done_o  (conv_done)
  );

  // Each field's result is picked up in the first cycle of the following state
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_CAPTURE;
      step_q  <= '0;
      start_q <= 1'b0;
      val_q   <= '0;
      nbits_q <= '0;
      cap_ctrl_q <= 1'b0;  cap_ampm_q <= 1'b0;
      cap_m_q <= '0;  cap_s_q <= '0;  cap_ms_q <= '0;
      h_bcd_q <= '0;  m_bcd_q <= '0;  s_bcd_q <= '0;
      disp_h_q <= '0; disp_m_q <= '0; disp_s_q <= '0; disp_ms_q <= '0;
      disp_ctrl_q <= 1'b0; disp_ampm_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      step_q  <= step_q + 4'd1;
      case (state_q)
        S_CAPTURE: begin
          cap_ctrl_q <= bus.Control;
          cap_ampm_q <= bus.AM_PM;
          cap_m_q    <= bus.Mins;
          cap_s_q    <= bus.Secs;
          cap_ms_q   <= bus.MSecs;
          val_q      <= 10'(bus.Hours);
          nbits_q    <= N_H;
          start_q    <= 1'b1;
          step_q     <= '0;
          state_q    <= S_CONV_H;
        end
        S_CONV_H: if (step_q == N_H) begin
          val_q <= 10'(cap_m_q); nbits_q <= N_M; start_q <= 1'b1;
          step_q <= '0; state_q <= S_CONV_M;
        end
        S_CONV_M: begin
          if (conv_done) h_bcd_q <= {bcd1, bcd0};
          if (step_q == N_M) begin
            val_q <= 10'(cap_s_q); nbits_q <= N_S; start_q <= 1'b1;
            step_q <= '0; state_q <= S_CONV_S;
          end
        end
        S_CONV_S: begin
          if (conv_done) m_bcd_q <= {bcd1, bcd0};
          if (step_q == N_S) begin
            val_q <= cap_ms_q; nbits_q <= N_MS; start_q <= 1'b1;
            step_q <= '0; state_q <= S_CONV_MS;
          end
        end
        S_CONV_MS: begin
          if (conv_done) s_bcd_q <= {bcd1, bcd0};
          if (step_q == N_MS) begin
            step_q <= '0; state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          disp_h_q    <= h_bcd_q;
          disp_m_q    <= m_bcd_q;
          disp_s_q    <= s_bcd_q;
          disp_ms_q   <= {bcd2, bcd1};
          disp_ctrl_q <= cap_ctrl_q;
          disp_ampm_q <= cap_ampm_q;
          step_q      <= '0;
          state_q     <= S_CAPTURE;
        end
        default: state_q <= S_CAPTURE;
      endcase
    end
  end

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [6:0]    dig_seg, seg_q;
  logic          dig_dp, dp_q;
  logic [7:0]    en_q;

  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (bus.Alarm) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    dig_seg = SEG_BLANK;
    dig_dp  = 1'b1;
    case (idx_q)
      DIG_H_T: begin
        dig_seg = seg_of(disp_h_q[7:4]);
`ifdef LEAD_BLANK_EN
        if (disp_h_q[7:4] == 4'd0) dig_seg = SEG_BLANK;
`endif
      end
      DIG_H_U:  begin dig_seg = seg_of(disp_h_q[3:0]); dig_dp = 1'b0; end
      DIG_M_T:  dig_seg = seg_of(disp_m_q[7:4]);
      DIG_M_U:  begin dig_seg = seg_of(disp_m_q[3:0]); dig_dp = 1'b0; end
      DIG_S_T:  dig_seg = seg_of(disp_s_q[7:4]);
      DIG_S_U:  begin dig_seg = seg_of(disp_s_q[3:0]); dig_dp = 1'b0; end
      DIG_MS_H: dig_seg = disp_ctrl_q ? (disp_ampm_q ? SEG_P : SEG_A)
                                      : seg_of(disp_ms_q[7:4]);
      default:  dig_seg = disp_ctrl_q ? SEG_BLANK : seg_of(disp_ms_q[3:0]);
    endcase
  end

  // Seg, Dp and Digit_En share one register stage so they never skew
  always_ff @(posedge Clock_5K or negedge Reset) begin
    if (!Reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      en_q        <= 8'hFF;
    end else begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= dig_seg;
      dp_q        <= dig_dp;
      en_q        <= blink_on_d ? ~(8'd1 << idx_q) : 8'hFF;
    end
  end

  assign bus.Seg       = seg_q;
  assign bus.Dp        = dp_q;
  assign bus.Digit_En  = en_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_drv.sv
// Scoreboard bench for seg_display_drv: directed time values, expected digit
// slots queued by the driver and compared by a scan monitor.
module tb_seg_display_drv;
  import disp_pkg::*;

  localparam int SCAN_DIV  = 5;
  localparam int BLINK_DIV = 1250;

`ifdef LEAD_BLANK_EN
  localparam logic [6:0] H_TENS_ZERO = 7'h7F;
`else
  localparam logic [6:0] H_TENS_ZERO = 7'h40;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  seg_display_drv_if bus();

  seg_display_drv #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .Clock_5K (clk),
    .Reset    (rst_n),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] sc(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [55:0] frame(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  // driver tasks
  task automatic push_digits(input logic [55:0] segs, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] en;
      logic       dp;
      en = ~(8'd1 << i);
      dp = (i == 2 || i == 4 || i == 6) ? 1'b0 : 1'b1;
      exp_q.push_back({en, segs[i*7 +: 7], dp});
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_pending_digits"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_phase(input int unsigned ph);
    int t;
    t = 0;
    while ((cyc % 32) != ph && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("phase_align", cyc % 32, ph);
  endtask

  task automatic set_time(input logic ctrl, input int h, input int m, input int s,
                          input int ms, input logic pm);
    bus.Control = ctrl;
    bus.Hours   = W_HOURS'(h);
    bus.Mins    = W_MINS'(m);
    bus.Secs    = W_SECS'(s);
    bus.MSecs   = W_MSECS'(ms);
    bus.AM_PM   = pm;
  endtask

  // scan monitor and scoreboard
  logic [7:0]  prev_en = 8'hFF;
  int          hold_cnt = 0;
  bit          armed = 1'b0;
  bit          check_scan = 1'b0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (bus.Digit_En !== prev_en) begin
      if (armed && check_scan && bus.Digit_En != 8'hFF) begin
        chk("slot_len", hold_cnt, SCAN_DIV);
        chk("scan_next", bus.Digit_En, {prev_en[6:0], prev_en[7]});
        chk("one_low", $countones(~bus.Digit_En), 1);
      end
      armed    = check_scan && (prev_en != 8'hFF) && (bus.Digit_En != 8'hFF);
      hold_cnt = 1;
      if (exp_q.size() > 0 && bus.Digit_En == exp_q[0][15:8]) begin
        e = exp_q.pop_front();
        chk($sformatf("seg_en%02h", bus.Digit_En), bus.Seg, e[7:1]);
        chk($sformatf("dp_en%02h", bus.Digit_En), bus.Dp, e[0]);
      end
    end else begin
      hold_cnt++;
    end
    prev_en = bus.Digit_En;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    bus.Alarm = 1'b0;
    set_time(1'b1, 12, 5, 9, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_digit_en", bus.Digit_En, 8'hFF);
      chk("rst_seg", bus.Seg, 7'h7F);
      chk("rst_dp", bus.Dp, 1'b1);
      chk("rst_state", bus.dbg_state, S_CAPTURE);
    end
    rst_n = 1'b1;
    check_scan = 1'b1;

    // 12:05:09 PM in clock mode
    repeat (64) @(negedge clk);
    push_digits(frame(sc(1), sc(2), sc(0), sc(5), sc(0), sc(9), 7'h0C, 7'h7F), 8);
    wait_drain("clock_pm");

    // stopwatch 00:59:59.98x
    set_time(1'b0, 0, 59, 59, 987, 1'b0);
    repeat (70) @(negedge clk);
    push_digits(frame(H_TENS_ZERO, sc(0), sc(5), sc(9), sc(5), sc(9), sc(9), sc(8)), 8);
    wait_drain("stopwatch");

    // out-of-range fields converted as-is, AM marker
    set_time(1'b1, 15, 63, 0, 5, 1'b0);
    repeat (70) @(negedge clk);
    push_digits(frame(sc(1), sc(5), sc(6), sc(3), sc(0), sc(0), 7'h08, 7'h7F), 8);
    wait_drain("range_am");

    // Secs change mid-pass must wait for the following COMMIT
    set_time(1'b1, 12, 5, 10, 0, 1'b1);
    repeat (70) @(negedge clk);
    push_digits(frame(sc(1), sc(2), sc(0), sc(5), sc(1), sc(0), 7'h0C, 7'h7F), 8);
    wait_drain("secs10");
    wait_phase(8);
    bus.Secs = 6'd11;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.Digit_En == 8'hFB) begin chk("secs_old_units", bus.Seg, sc(0)); seen++; end
      if (bus.Digit_En == 8'hF7) chk("secs_old_tens", bus.Seg, sc(1));
    end
    chk("secs_old_seen", seen > 0, 1);
    repeat (20) @(negedge clk);
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.Digit_En == 8'hFB) begin chk("secs_new_units", bus.Seg, sc(1)); seen++; end
      if (bus.Digit_En == 8'hF7) chk("secs_new_tens", bus.Seg, sc(1));
    end
    chk("secs_new_seen", seen > 0, 1);

    // alarm blink: OFF windows are the odd 1250-cycle windows
    check_scan = 1'b0;
    bus.Alarm = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (((k / BLINK_DIV) % 2) == 1) chk("blink_off", bus.Digit_En, 8'hFF);
      else chk("blink_on_one_low", $countones(~bus.Digit_En), 1);
    end
    bus.Alarm = 1'b0;
    @(negedge clk);
    chk("alarm_resume", $countones(~bus.Digit_En), 1);
    check_scan = 1'b1;
    repeat (30) @(negedge clk);

    // one-cycle reset pulse during CONV_MS
    wait_phase(25);
    check_scan = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("pulse_digit_en", bus.Digit_En, 8'hFF);
    chk("pulse_seg", bus.Seg, 7'h7F);
    chk("pulse_dp", bus.Dp, 1'b1);
    push_digits(frame(7'h7F, 7'h7F, sc(0), sc(0), sc(0), sc(0), sc(0), sc(0)), 6);
    @(negedge clk);
    rst_n = 1'b1;
    check_scan = 1'b1;
    wait_drain("post_reset_zero");
    repeat (10) @(negedge clk);
    push_digits(frame(sc(1), sc(2), sc(0), sc(5), sc(1), sc(1), 7'h0C, 7'h7F), 8);
    wait_drain("post_reset_value");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
